// File: rtl/aes_128_iter.sv
// Iterative AES-128 encryption core: UNROLL rounds per clock, round keys expanded on the fly,
// valid/ready handshakes on both sides.
module aes_128_iter #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  // state  | meaning
  // IDLE   | waiting for a block, in_ready high
  // RUN    | applying UNROLL rounds per cycle
  // DONE   | ciphertext presented, waiting for out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] STEP     = 4'(UNROLL);
  localparam logic [3:0] LAST_RND = 4'(11 - UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_128_iter: UNROLL must be 1, 2, 5 or 10");
  end

  // Highest byte of the constant is sbox(8'h00), so the table is indexed with ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w3, t, w4, w5, w6, w7;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(r), 24'h0};
    w4 = k[127:96] ^ t;
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = w3 ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] d, input logic [127:0] rk,
                                             input logic final_rnd);
    logic [7:0]   s  [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] m;
    for (int i = 0; i < 16; i++) s[i] = sbox(d[127-8*i -: 8]);
    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = s[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (final_rnd) begin
        m[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        m[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return m ^ rk;
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic [127:0] run_data, run_key;

  always_comb begin
    logic [127:0] d_w, k_w;
    logic [3:0]   r_w;
    d_w = data_q;
    k_w = key_q;
    r_w = rnd_q;
    for (int u = 0; u < UNROLL; u++) begin
      k_w = next_key(k_w, r_w);
      d_w = aes_round(d_w, k_w, r_w == 4'd10);
      r_w = r_w + 4'd1;
    end
    run_data = d_w;
    run_key  = k_w;
  end

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    data_d = data_q;
    key_d  = key_q;
    out_d  = out_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = state ^ key;
          key_d  = key;
          rnd_d  = 4'd1;
          fsm_d  = S_RUN;
        end
      end
      S_RUN: begin
        data_d = run_data;
        key_d  = run_key;
        rnd_d  = rnd_q + STEP;
        if (rnd_q == LAST_RND) begin
          out_d = run_data;
          fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      rnd_q  <= 4'd0;
      data_q <= 128'h0;
      key_q  <= 128'h0;
      out_q  <= 128'h0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      data_q <= data_d;
      key_q  <= key_d;
      out_q  <= out_d;
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_aes_128_iter.sv
// Directed bench for aes_128_iter: one instance per legal UNROLL, FIPS-197 and SP 800-38A
// known-answer vectors, latency, backpressure, busy input, reset abort and back-to-back blocks.
module tb_aes_128_iter;

  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] PT_E = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_E = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  localparam logic [127:0] V_PT [4] = '{PT_B, PT_C, 128'h0, PT_E};
  localparam logic [127:0] V_K  [4] = '{K_B,  K_C,  128'h0, K_B};
  localparam logic [127:0] V_CT [4] = '{CT_B, CT_C, CT_Z, CT_E};
  localparam int           LAT  [4] = '{10, 5, 2, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] pt, ck;
  logic         ir   [4];
  logic         ov   [4];
  logic         ordy [4];
  logic [127:0] ct   [4];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_128_iter #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .state    (pt),
      .key      (ck),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out      (ct[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic start_block(input logic [127:0] p, input logic [127:0] k);
    in_valid = 1'b1;
    pt = p;
    ck = k;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int idx, output int lat);
    lat = 0;
    while (!ov[idx] && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic settle();
    repeat (14) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat, bad, t;
    int acc [4];
    logic stable;

    rst = 1'b1;
    in_valid = 1'b0;
    pt = '0;
    ck = '0;
    for (int i = 0; i < 4; i++) ordy[i] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(ir[0]), 128'd1);
    check("rst_out_valid", 128'(ov[0]), 128'd0);
    check("rst_out", ct[0], 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 App. B on UNROLL=1
    start_block(PT_B, K_B);
    wait_done(0, lat);
    check("appb_latency", 128'(lat), 128'd10);
    check("appb_ct", ct[0], CT_B);
    @(negedge clk);
    check("appb_ready_after_hs", 128'(ir[0]), 128'd1);
    settle();

    // FIPS-197 App. C.1 on every UNROLL
    for (int i = 0; i < 4; i++) begin
      check($sformatf("c1_ready_u%0d", LAT[3-i]), 128'(ir[i]), 128'd1);
      start_block(PT_C, K_C);
      wait_done(i, lat);
      check($sformatf("c1_latency_idx%0d", i), 128'(lat), 128'(LAT[i]));
      check($sformatf("c1_ct_idx%0d", i), ct[i], CT_C);
      settle();
    end

    // Backpressure
    ordy[0] = 1'b0;
    start_block(PT_B, K_B);
    wait_done(0, lat);
    check("bp_ct", ct[0], CT_B);
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (!(ov[0] === 1'b1 && ct[0] === CT_B && ir[0] === 1'b0)) stable = 1'b0;
    end
    check("bp_held_stable", 128'(stable), 128'd1);
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_consumed_valid", 128'(ov[0]), 128'd0);
    check("bp_consumed_ready", 128'(ir[0]), 128'd1);
    settle();

    // Random traffic on the input side while a block is running
    start_block(PT_B, K_B);
    bad = 0;
    t = 0;
    while (!ov[0] && t < 40) begin
      if (ir[0] !== 1'b0) bad++;
      in_valid = 1'($urandom_range(0, 1));
      pt = {$urandom, $urandom, $urandom, $urandom};
      ck = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    check("busy_done", 128'(ov[0]), 128'd1);
    check("busy_ct", ct[0], CT_B);
    check("busy_ready_low", 128'(bad), 128'd0);
    settle();

    // Reset in RUN cycle 4
    start_block(PT_C, K_C);
    repeat (3) @(negedge clk);
    do_reset();
    check("rst_mid_valid", 128'(ov[0]), 128'd0);
    check("rst_mid_ready", 128'(ir[0]), 128'd1);
    check("rst_mid_out", ct[0], 128'h0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) bad++;
    end
    check("rst_mid_no_valid", 128'(bad), 128'd0);
    start_block(PT_C, K_C);
    wait_done(0, lat);
    check("rst_after_ct", ct[0], CT_C);
    check("rst_after_latency", 128'(lat), 128'd10);
    settle();

    // Back-to-back, UNROLL=2
    do_reset();
    in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      t = 0;
      while (!ir[1] && t < 40) begin
        @(posedge clk);
        @(negedge clk);
        t++;
      end
      pt = V_PT[b];
      ck = V_K[b];
      @(posedge clk);
      @(negedge clk);
      acc[b] = cyc;
      wait_done(1, lat);
      check($sformatf("b2b_ct%0d", b), ct[1], V_CT[b]);
    end
    in_valid = 1'b0;
    for (int b = 1; b < 4; b++)
      check($sformatf("b2b_gap%0d", b), 128'(acc[b] - acc[b-1]), 128'd7);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_128_iter.md
# aes_128_iter

Iterative, parametrised AES-128 encryption core with valid/ready handshakes, successor to the fully pipelined `aes_128`. It computes UNROLL rounds per clock, trading area for latency, and reuses the existing round and key-expansion primitives (`one_round`, `final_round`, S-box tables). It sits between a block source and a ciphertext sink that may apply backpressure, where a 10-stage pipeline is too large.

## Interface
- UNROLL, 1, rounds computed per clock; legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `state`/`key` hold a block to encrypt.
- in_ready  output  1  core can accept a block; high only in IDLE.
- state  input  128  plaintext, FIPS-197 byte order (MSB = byte 0).
- key  input  128  cipher key, same byte order.
- out_valid  output  1  `out` holds a finished ciphertext.
- out_ready  input  1  sink accepts `out` this cycle.
- out  output  128  ciphertext; registered.

## Operation
- N = 10 / UNROLL is the number of RUN cycles per block.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready: load data_reg = state ^ key (initial AddRoundKey), key_reg = key, round counter rnd = 1. Go to RUN.
- RUN
  - Each cycle applies rounds rnd .. rnd+UNROLL-1 combinationally to data_reg and key_reg, with each round's key expanded on the fly.
  - Rcon is derived from the round index: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Round 10 is `final_round` (no MixColumns). Rounds 1–9 are `one_round`.
  - At each edge: rnd += UNROLL; data_reg and key_reg take the results.
  - When round 10 has just been applied: out <= result, go to DONE.
- DONE
  - out_valid = 1 and `out` is held stable.
  - On out_ready: go to IDLE.
- in_valid is ignored outside IDLE. `state` and `key` need to be stable only on the accepting edge.
- `out` keeps the last ciphertext after the handshake until the next block completes.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from any input.

## Timing
- Reset: state = IDLE, out_valid = 0, in_ready = 1, out = 0, rnd = 0, data_reg = 0, key_reg = 0.
- Latency: if a block is accepted at edge E0, out_valid rises after edge E0+N, with `out` valid in the same cycle. That is 10 / 5 / 2 / 1 cycles for UNROLL = 1 / 2 / 5 / 10.
- The output handshake completes on the edge where out_valid & out_ready are both high. in_ready is high in the cycle after that edge.
- Throughput with out_ready held high: one block per N+2 cycles.
- Backpressure: while out_ready = 0 in DONE, `out` and out_valid are held indefinitely and in_ready stays 0.
- Reset mid-RUN or mid-DONE: on the next edge the core returns to reset values. The aborted block never produces out_valid.
- rst has priority over any handshake on the same edge.
- in_valid and out_ready are never high-impact simultaneously in one state. If both are asserted in DONE, only the output handshake takes effect and the input is taken in a later IDLE cycle.

## Test plan
- FIPS-197 App. B, UNROLL = 1: state = 3243f6a8885a308d313198a2e0370734, key = 2b7e151628aed2a6abf7158809cf4f3c -> out = 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 cycles after acceptance.
- FIPS-197 App. C.1, repeated for UNROLL = 1, 2, 5, 10: key = 000102030405060708090a0b0c0d0e0f, state = 00112233445566778899aabbccddeeff -> out = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Latency must be 10, 5, 2 and 1 cycles respectively.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> out_valid and `out` are stable, in_ready = 0, and the block is consumed on the first edge with out_ready = 1.
- Busy input: toggle in_valid with random data during RUN -> the data is ignored, the result still equals the App. B ciphertext, and in_ready = 0 throughout.
- Reset mid-operation: assert rst for 1 cycle at RUN cycle 4 -> no out_valid, in_ready = 1 next cycle, out = 0. A following App. C.1 block then encrypts correctly.
- Back-to-back: 4 blocks with in_valid and out_ready held high, UNROLL = 2 -> acceptances 7 cycles apart, ciphertexts in order, each matching the software model.
